hack_cpu_mc: RTL and testbench
==============================

HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Interface
REQ-001 Parameter WIDTH, default 16: data/instruction width; SHALL be >= 16.
REQ-002 Parameter AW, default 15: instruction and data address width; SHALL be <= WIDTH-1.
REQ-003 Port clock  input  1: single clock; all state changes on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port instruction  input  WIDTH: instruction word, valid when imem_ack=1.
REQ-006 Port imem_ack  input  1: instruction fetch complete.
REQ-007 Port dmem_rdata  input  WIDTH: data read value, valid when dmem_ack=1 during a read.
REQ-008 Port dmem_ack  input  1: data read or write complete.
REQ-009 Port imem_req  output  1: instruction fetch request.
REQ-010 Port imem_addr  output  AW: fetch address, equal to pc.
REQ-011 Port dmem_rd / dmem_wr  output  1 each: data read / write request, mutually exclusive.
REQ-012 Port dmem_addr  output  AW: data address. Port dmem_wdata  output  WIDTH: write data.
REQ-013 Port pc  output  AW: program counter. Port retire  output  1: one-cycle pulse per completed instruction.

Function
REQ-014 States SHALL be IDLE, FETCH, EXEC, MREAD and MWRITE; all outputs SHALL be registered or decoded from state only.
REQ-015 IDLE -> FETCH unconditionally on the next edge.
REQ-016 FETCH: imem_req=1, imem_addr=pc; on a cycle with imem_ack=1, latch instruction into IR and go to EXEC; otherwise hold all request outputs stable.
REQ-017 IR[WIDTH-1]=0 (A-instruction) in EXEC: A <= IR with MSB cleared; pc <= pc+1; retire=1; go to FETCH.
REQ-018 C-instruction: IR[WIDTH-1]=1; bits [WIDTH-2:13] ignored; a=IR[12], c1..c6=IR[11:6] (zx,nx,zy,ny,f,no), dA/dD/dM=IR[5:3], jLT/jEQ/jGT=IR[2:0].
REQ-019 EXEC with a=1 and no M value latched for this instruction: go to MREAD without modifying A, D or pc.
REQ-020 MREAD: dmem_rd=1, dmem_addr=A[AW-1:0]; on dmem_ack, latch dmem_rdata as M, mark M valid, return to EXEC.
REQ-021 EXEC computes ALU(x=D, y=a?M:A) per Hack semantics: zx then nx on x, zy then ny on y, f selects x+y (mod 2^WIDTH) or x&y, no inverts the result.
REQ-022 zr = (result==0); ng = result[WIDTH-1]; jump = (jLT&ng) | (jEQ&zr) | (jGT&~zr&~ng).
REQ-023 In EXEC: dD loads D; dA loads A; pc <= jump ? old A[AW-1:0] : pc+1, where old A is A's value before this EXEC edge, even when dA=1.
REQ-024 EXEC with dM=0: retire=1, go to FETCH. With dM=1: latch dmem_addr=old A[AW-1:0] and dmem_wdata=result, go to MWRITE.
REQ-025 MWRITE: dmem_wr=1 with latched address/data held stable; on dmem_ack, retire=1, go to FETCH.
REQ-026 pc+1 SHALL wrap modulo 2^AW.
REQ-027 imem_ack outside FETCH, and dmem_ack outside MREAD/MWRITE, SHALL be ignored.
REQ-028 The M-valid flag SHALL clear when each instruction retires.
REQ-029 Latency with ack in the first request cycle: A-instruction 2 cycles; C no M 2; C read M 4; C write M 3; C read and write 5; each wait cycle adds 1.

Reset
REQ-030 While reset=1: state=IDLE, pc=0, A=0, D=0, IR=0, M-valid=0, and imem_req, dmem_rd, dmem_wr, retire, dmem_addr, dmem_wdata all 0.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately with no retire and no further write; first fetch after release is at address 0.

Verification
REQ-032 Release reset, imem_ack always 1, program @0=0x0005, @1=0xEC10 (D=A) -> after retire #2, D=5, pc=2; first imem_req one cycle after release.
REQ-033 A=7, D=3, C "M=D+A" (0xE088) with dmem_ack delayed 3 cycles -> dmem_wr held 4 cycles, addr=7, data=10, single retire.
REQ-034 A=100, mem[100]=0xFFFF, "D=M;JLT" (0xFC14) -> dmem_rd at 100, D=0xFFFF, pc=100, latency 4 cycles with zero waits.
REQ-035 A=9, "A=-1;JMP" (0xEEA7) -> pc=9 (old A), A=0xFFFF.
REQ-036 pc=0x7FFF executing 0x0001 -> pc wraps to 0, A=1.
REQ-037 Reset asserted during MWRITE wait -> dmem_wr drops immediately, no retire, pc=0 after release.

Source files
------------

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with handshaked instruction and data memory ports.
// Ports:
//   clock, reset                 - single rising-edge clock, async active-high reset
//   instruction, imem_ack        - fetched word and its completion strobe
//   dmem_rdata, dmem_ack         - data read value and read/write completion strobe
//   imem_req, imem_addr          - fetch request and address (mirrors pc)
//   dmem_rd, dmem_wr             - data read / write requests (never both)
//   dmem_addr, dmem_wdata        - data address and write data
//   pc, retire                   - program counter and per-instruction retire pulse
module hack_cpu_mc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] instruction,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic [AW-1:0]    imem_addr,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic [AW-1:0]    dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [AW-1:0]    pc,
    output logic             retire
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MREAD, MWRITE} state_t;

    state_t           state, state_n;
    logic             retire_n;
    logic [WIDTH-1:0] ir, a_reg, d_reg, m_reg;
    logic             m_valid;

    // Instruction field decode
    logic is_c, a_bit, zx, nx, zy, ny, fn, no, dst_a, dst_d, dst_m, j_lt, j_eq, j_gt;
    assign is_c  = ir[WIDTH-1];
    assign a_bit = ir[12];
    assign zx    = ir[11];
    assign nx    = ir[10];
    assign zy    = ir[9];
    assign ny    = ir[8];
    assign fn    = ir[7];
    assign no    = ir[6];
    assign dst_a = ir[5];
    assign dst_d = ir[4];
    assign dst_m = ir[3];
    assign j_lt  = ir[2];
    assign j_eq  = ir[1];
    assign j_gt  = ir[0];

    // Hack ALU: x = D, y = A or M
    logic [WIDTH-1:0] x0, x1, y0, y1, r0, alu_res;
    logic             zr, ng, jump;
    always_comb begin
        x0      = zx ? '0 : d_reg;
        x1      = nx ? ~x0 : x0;
        y0      = zy ? '0 : (a_bit ? m_reg : a_reg);
        y1      = ny ? ~y0 : y0;
        r0      = fn ? (x1 + y1) : (x1 & y1);
        alu_res = no ? ~r0 : r0;
        zr      = (alu_res == '0);
        ng      = alu_res[WIDTH-1];
        jump    = (j_lt & ng) | (j_eq & zr) | (j_gt & ~zr & ~ng);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and retire decode
    always_comb begin
        state_n  = state;
        retire_n = 1'b0;
        case (state)
            IDLE:   state_n = FETCH;
            FETCH:  if (imem_ack) state_n = EXEC;
            EXEC: begin
                if (!is_c) begin
                    retire_n = 1'b1;
                    state_n  = FETCH;
                end else if (a_bit && !m_valid) begin
                    state_n = MREAD;
                end else if (dst_m) begin
                    state_n = MWRITE;
                end else begin
                    retire_n = 1'b1;
                    state_n  = FETCH;
                end
            end
            MREAD:  if (dmem_ack) state_n = EXEC;
            MWRITE: begin
                if (dmem_ack) begin
                    retire_n = 1'b1;
                    state_n  = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered request outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir         <= '0;
            a_reg      <= '0;
            d_reg      <= '0;
            m_reg      <= '0;
            m_valid    <= 1'b0;
            pc         <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            imem_req   <= 1'b0;
            dmem_rd    <= 1'b0;
            dmem_wr    <= 1'b0;
            retire     <= 1'b0;
        end else begin
            imem_req <= (state_n == FETCH);
            dmem_rd  <= (state_n == MREAD);
            dmem_wr  <= (state_n == MWRITE);
            retire   <= retire_n;
            case (state)
                FETCH: if (imem_ack) ir <= instruction;
                EXEC: begin
                    if (!is_c) begin
                        a_reg <= {1'b0, ir[WIDTH-2:0]};
                        pc    <= pc + AW'(1);
                    end else if (a_bit && !m_valid) begin
                        dmem_addr <= a_reg[AW-1:0];
                    end else begin
                        if (dst_d) d_reg <= alu_res;
                        if (dst_a) a_reg <= alu_res;
                        // Jump target is A as it was before this edge
                        pc <= jump ? a_reg[AW-1:0] : pc + AW'(1);
                        if (dst_m) begin
                            dmem_addr  <= a_reg[AW-1:0];
                            dmem_wdata <= alu_res;
                        end
                    end
                end
                MREAD: begin
                    if (dmem_ack) begin
                        m_reg   <= dmem_rdata;
                        m_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
            // A latched M belongs to one instruction only
            if (retire_n) m_valid <= 1'b0;
        end
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed scoreboard bench for hack_cpu_mc with behavioural instruction/data memories.
module tb_hack_cpu_mc;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 15;

    logic             clock, reset;
    logic [WIDTH-1:0] instruction, dmem_rdata, dmem_wdata;
    logic             imem_ack, dmem_ack, imem_req, dmem_rd, dmem_wr, retire;
    logic [AW-1:0]    imem_addr, dmem_addr, pc;

    hack_cpu_mc #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .imem_ack(imem_ack),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .imem_req(imem_req),
        .imem_addr(imem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .pc(pc), .retire(retire)
    );

    typedef struct {
        logic [AW-1:0]    pc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] d;
        int               gap;
    } exp_t;

    exp_t             sb[$];
    logic [31:0]      wr_q[$];
    logic [AW-1:0]    rd_q[$];
    logic [WIDTH-1:0] imem [0:(1<<AW)-1];
    logic [WIDTH-1:0] dmem [0:(1<<AW)-1];
    int               dwait, dcnt, wr_cycles;
    logic             spurious;
    int               n_cmp, n_fail;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory responder: imem_ack held high, dmem_ack after dwait wait cycles
    initial begin
        imem_ack    = 1'b1;
        dmem_ack    = 1'b0;
        dmem_rdata  = '0;
        instruction = '0;
        dcnt        = 0;
        forever begin
            @(negedge clock);
            instruction = imem[imem_addr];
            if (dmem_wr) wr_cycles++;
            if (dmem_rd || dmem_wr) begin
                if (dcnt >= dwait) begin
                    dmem_ack = 1'b1;
                    dcnt     = 0;
                    if (dmem_rd) begin
                        dmem_rdata = dmem[dmem_addr];
                        rd_q.push_back(dmem_addr);
                    end else begin
                        dmem[dmem_addr] = dmem_wdata;
                        wr_q.push_back({1'b0, dmem_addr, dmem_wdata});
                    end
                end else begin
                    dmem_ack = 1'b0;
                    dcnt++;
                end
            end else begin
                dmem_ack   = spurious;
                dmem_rdata = 16'hDEAD;
                dcnt       = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] p, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] d, input int gap);
        exp_t e;
        e.pc = p; e.a = a; e.d = d; e.gap = gap;
        sb.push_back(e);
    endtask

    // Wait for the next retire pulse and compare it against the scoreboard head
    task automatic expect_retire(input string tag);
        exp_t e;
        int   cnt;
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (!retire && cnt < 200);
        check({tag, "_retire_seen"}, 32'(retire), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_pc"},  32'(pc),        32'(e.pc));
            check({tag, "_a"},   32'(dut.a_reg), 32'(e.a));
            check({tag, "_d"},   32'(dut.d_reg), 32'(e.d));
            check({tag, "_gap"}, 32'(cnt),       32'(e.gap));
        end
    endtask

    task automatic expect_write(input string tag, input logic [AW-1:0] addr,
                                input logic [WIDTH-1:0] data);
        logic [31:0] w;
        check({tag, "_wr_present"}, 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            check({tag, "_wr"}, w, {1'b0, addr, data});
        end
    endtask

    task automatic expect_read(input string tag, input logic [AW-1:0] addr);
        logic [AW-1:0] r;
        check({tag, "_rd_present"}, 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
            r = rd_q.pop_front();
            check({tag, "_rd_addr"}, 32'(r), 32'(addr));
        end
    endtask

    // Hold reset, clear memories and bookkeeping
    task automatic start_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < (1 << AW); i++) begin
            imem[i] = '0;
            dmem[i] = '0;
        end
        sb.delete();
        wr_q.delete();
        rd_q.delete();
        dwait     = 0;
        spurious  = 1'b0;
        wr_cycles = 0;
        @(negedge clock);
    endtask

    task automatic release_reset();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;

        // Reset values, first fetch timing, A then D=A
        start_reset();
        imem[0] = 16'h0005;
        imem[1] = 16'hEC10;
        check("rst_imem_req",   32'(imem_req),   32'd0);
        check("rst_dmem_rd",    32'(dmem_rd),    32'd0);
        check("rst_dmem_wr",    32'(dmem_wr),    32'd0);
        check("rst_retire",     32'(retire),     32'd0);
        check("rst_pc",         32'(pc),         32'd0);
        check("rst_dmem_addr",  32'(dmem_addr),  32'd0);
        check("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
        release_reset();
        @(negedge clock);
        check("t1_first_req",  32'(imem_req),  32'd1);
        check("t1_first_addr", 32'(imem_addr), 32'd0);
        push_exp(15'd1, 16'd5, 16'd0, 2);
        push_exp(15'd2, 16'd5, 16'd5, 2);
        expect_retire("t1_i0");
        expect_retire("t1_i1");

        // M=D+A with three write wait cycles
        start_reset();
        imem[0] = 16'h0003;
        imem[1] = 16'hEC10;
        imem[2] = 16'h0007;
        imem[3] = 16'hE088;
        dwait   = 3;
        release_reset();
        push_exp(15'd1, 16'd3, 16'd0, 3);
        push_exp(15'd2, 16'd3, 16'd3, 2);
        push_exp(15'd3, 16'd7, 16'd3, 2);
        push_exp(15'd4, 16'd7, 16'd3, 6);
        push_exp(15'd5, 16'd0, 16'd3, 2);
        for (int i = 0; i < 5; i++) expect_retire("t2");
        check("t2_wr_cycles", 32'(wr_cycles), 32'd4);
        expect_write("t2", 15'd7, 16'd10);
        check("t2_no_extra_wr", 32'(wr_q.size()), 32'd0);

        // D=M;JLT from address 100, stray dmem_ack outside reads
        start_reset();
        imem[0]   = 16'h0064;
        imem[1]   = 16'hFC14;
        dmem[100] = 16'hFFFF;
        spurious  = 1'b1;
        release_reset();
        push_exp(15'd1,   16'd100, 16'd0,    3);
        push_exp(15'd100, 16'd100, 16'hFFFF, 4);
        expect_retire("t3_i0");
        expect_retire("t3_i1");
        expect_read("t3", 15'd100);

        // A=-1;JMP jumps to the old A
        start_reset();
        imem[0] = 16'h0009;
        imem[1] = 16'hEEA7;
        release_reset();
        push_exp(15'd1, 16'd9,    16'd0, 3);
        push_exp(15'd9, 16'hFFFF, 16'd0, 2);
        expect_retire("t4_i0");
        expect_retire("t4_i1");

        // pc wraps from the top of instruction memory
        start_reset();
        imem[0]       = 16'h7FFF;
        imem[1]       = 16'hE007;
        imem[15'h7FFF] = 16'h0001;
        release_reset();
        push_exp(15'd1,      16'h7FFF, 16'd0, 3);
        push_exp(15'h7FFF,   16'h7FFF, 16'd0, 2);
        push_exp(15'd0,      16'd1,    16'd0, 2);
        for (int i = 0; i < 3; i++) expect_retire("t5");

        // M=M+1 (read then write), then D=M must re-read memory
        start_reset();
        imem[0]  = 16'h0020;
        imem[1]  = 16'hFDC8;
        imem[2]  = 16'hFC10;
        dmem[32] = 16'h0041;
        release_reset();
        push_exp(15'd1, 16'h0020, 16'd0,    3);
        push_exp(15'd2, 16'h0020, 16'd0,    5);
        push_exp(15'd3, 16'h0020, 16'h0042, 4);
        for (int i = 0; i < 3; i++) expect_retire("t6");
        expect_write("t6", 15'd32, 16'h0042);
        expect_read("t6_first", 15'd32);
        expect_read("t6_second", 15'd32);

        // Reset during an outstanding write aborts it
        start_reset();
        imem[0] = 16'h0007;
        imem[1] = 16'hE088;
        dwait   = 20;
        release_reset();
        push_exp(15'd1, 16'd7, 16'd0, 3);
        expect_retire("t7_i0");
        for (int i = 0; i < 50 && !dmem_wr; i++) @(negedge clock);
        check("t7_wr_started", 32'(dmem_wr), 32'd1);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("t7_wr_dropped", 32'(dmem_wr),   32'd0);
        check("t7_no_retire",  32'(retire),    32'd0);
        check("t7_addr_clr",   32'(dmem_addr), 32'd0);
        repeat (2) @(negedge clock);
        check("t7_no_retire_held", 32'(retire),      32'd0);
        check("t7_no_write",       32'(wr_q.size()), 32'd0);
        check("t7_pc_rst",         32'(pc),          32'd0);
        release_reset();
        @(negedge clock);
        check("t7_refetch_req",  32'(imem_req),  32'd1);
        check("t7_refetch_addr", 32'(imem_addr), 32'd0);
        push_exp(15'd1, 16'd7, 16'd0, 2);
        expect_retire("t7_again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
